// File: rtl/xb_crc8_pkg.sv
// Shared types and defaults for the bit-serial CRC-8 engine.
package xb_crc8_pkg;

    localparam int unsigned CRC_W = 8;

    localparam logic [CRC_W-1:0] CRC8_POLY_DEF = 8'h07;
    localparam logic [CRC_W-1:0] CRC8_INIT_DEF = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } crc_state_e;

    // One MSB-first CRC step; the x^8 term of the polynomial is implicit.
    function automatic logic [CRC_W-1:0] crc8_step(
        input logic [CRC_W-1:0] crc,
        input logic             din,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : CRC_W'(0));
    endfunction

endpackage

// File: rtl/xb_byte_fifo.sv
// Small byte FIFO with synchronous flush; caller qualifies push/pop against full/empty.
module xb_byte_fifo
    import xb_crc8_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [CRC_W-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic [CRC_W-1:0] o_dout_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CRC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    assign o_full_c  = (r_count == (AW+1)'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_dout_c  = r_mem[r_rptr];

endmodule

// File: rtl/xb_crc8_engine.sv
// Bit-serial CRC-8 engine behind an AVR register wrapper, one bit per enabled cycle.
// Define XB_CRC8_INFIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register.
module xb_crc8_engine
    import xb_crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY       = CRC8_POLY_DEF,
    parameter logic [CRC_W-1:0] INIT       = CRC8_INIT_DEF,
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clken,
    input  logic             enable,
    input  logic             crc_clr,
    input  logic             data_ex1_we,
    input  logic [CRC_W-1:0] data_ex1,
    output logic [CRC_W-1:0] data_ex2,
    output logic             busy,
    output logic             overflow
);

    crc_state_e       r_state;
    crc_state_e       w_state_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [CRC_W-1:0] r_shift;
    logic [CRC_W-1:0] w_shift_nxt;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_nxt;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic [CRC_W-1:0] w_dout;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;

    // Clear wins over everything; a push into a full buffer is fine if a pop frees a slot.
    assign w_flush = clken & crc_clr;
    assign w_pop   = clken & ~crc_clr & enable & (r_state == ST_IDLE) & ~w_empty;
    assign w_push  = clken & ~crc_clr & data_ex1_we & (~w_full | w_pop);

`ifdef XB_CRC8_INFIFO_EN
    xb_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .i_flush   (w_flush),
        .i_push    (w_push),
        .i_din     (data_ex1),
        .i_pop     (w_pop),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_dout_c  (w_dout)
    );
`else
    logic             r_hold_vld;
    logic [CRC_W-1:0] r_hold;
    logic             w_unused_depth;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
        end else if (w_flush) begin
            r_hold_vld <= 1'b0;
        end else if (w_push) begin
            r_hold_vld <= 1'b1;
            r_hold     <= data_ex1;
        end else if (w_pop) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign w_full         = r_hold_vld;
    assign w_empty        = ~r_hold_vld;
    assign w_dout         = r_hold;
    assign w_unused_depth = |FIFO_DEPTH;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_crc     <= INIT;
        end else if (clken) begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_crc     <= w_crc_nxt;
        end
    end

    // Everything holds while enable is low, so a paused byte resumes mid-shift.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_crc_nxt     = r_crc;
        if (crc_clr) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
            w_crc_nxt     = INIT;
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_shift_nxt   = w_dout;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w_crc_nxt     = crc8_step(r_crc, r_shift[CRC_W-1], POLY);
                    w_shift_nxt   = {r_shift[CRC_W-2:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (clken) begin
            if (crc_clr)                                  r_ovf <= 1'b0;
            else if (data_ex1_we && w_full && !w_pop)     r_ovf <= 1'b1;
        end
    end

    assign data_ex2 = r_crc;
    assign overflow = r_ovf;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule
